// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the MixColumns stage FSM encoding.
package aes_pkg;

   localparam int          AES_STATE_W = 128;
   localparam int          AES_WORD_W  = 32;
   localparam int          AES_NCOLS   = AES_STATE_W / AES_WORD_W;
   localparam logic [7:0]  AES_GF_POLY = 8'h1b;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_e;

endpackage

// File: rtl/mix_columns_seq_if.sv
// Upstream/downstream valid-ready bundle for the MixColumns stage.
interface mix_columns_seq_if;
   import aes_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [AES_STATE_W-1:0] in_state;
   logic                   in_final;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_STATE_W-1:0] out_state;

   modport master (
      output in_valid, in_state, in_final, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, in_final, out_ready,
      output in_ready, out_valid, out_state
   );

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column; row 0 is the most significant byte.
module mix_single_column
   import aes_pkg::*;
(
   input  logic [AES_WORD_W-1:0] col_in,
   output logic [AES_WORD_W-1:0] col_out
);

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_GF_POLY : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] x0, x1, x2, x3;

   assign {a0, a1, a2, a3} = col_in;
   assign x0 = xtime(a0);
   assign x1 = xtime(a1);
   assign x2 = xtime(a2);
   assign x3 = xtime(a3);

   // 3a is folded in as xtime(a)^a
   assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
   assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
   assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
   assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns stage: COLS_PER_CYCLE columns per clock, valid/ready both sides,
// with a final-round bypass that keeps identical timing.
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mix_columns_seq_if.slave  bus
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(AES_NCOLS - COLS_PER_CYCLE);

   mc_state_e             state_q, state_d;
   logic [1:0]            cnt_q;
   logic                  final_q;
   logic [AES_WORD_W-1:0] cap_q [AES_NCOLS];
   logic [AES_WORD_W-1:0] res_q [AES_NCOLS];
   logic                  accept;

   logic [1:0]            col_sel [COLS_PER_CYCLE];
   logic [AES_WORD_W-1:0] col_in  [COLS_PER_CYCLE];
   logic [AES_WORD_W-1:0] col_out [COLS_PER_CYCLE];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
      assign col_sel[g] = cnt_q + 2'(g);
      assign col_in[g]  = cap_q[col_sel[g]];

      mix_single_column u_mix (
         .col_in  (col_in[g]),
         .col_out (col_out[g])
      );
   end

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      bus.in_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (cnt_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            // Accepting in the same cycle the result leaves gives back-to-back blocks.
            bus.in_ready = bus.out_ready;
            if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_state = {res_q[0], res_q[1], res_q[2], res_q[3]};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: the capture and result arrays are small flops, reset to zero so a reset never exposes stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         final_q <= 1'b0;
         for (int i = 0; i < AES_NCOLS; i++) begin
            cap_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else if (accept) begin
         cnt_q   <= '0;
         final_q <= bus.in_final;
         for (int i = 0; i < AES_NCOLS; i++) begin
            cap_q[i] <= bus.in_state[AES_STATE_W-1-AES_WORD_W*i -: AES_WORD_W];
         end
      end else if (state_q == BUSY) begin
         cnt_q <= cnt_q + CNT_STEP;
         for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            res_q[col_sel[g]] <= final_q ? col_in[g] : col_out[g];
         end
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) driven from
// one vector table, plus backpressure/back-to-back and mid-BUSY reset sequences.
module tb_mix_columns_seq;
   import aes_pkg::*;

   typedef struct {
      logic [127:0] st;
      logic         fin;
      logic [127:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] in_state;
   logic         in_final;
   logic [2:0]   in_valid;
   logic [2:0]   out_ready;
   logic [2:0]   in_ready;
   logic [2:0]   out_valid;
   logic [383:0] out_state_all;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_seq_if bus ();

      assign bus.in_valid  = in_valid[g];
      assign bus.in_state  = in_state;
      assign bus.in_final  = in_final;
      assign bus.out_ready = out_ready[g];
      assign in_ready[g]   = bus.in_ready;
      assign out_valid[g]  = bus.out_valid;
      assign out_state_all[g*128 +: 128] = bus.out_state;

      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   function automatic logic [127:0] out_st(input int idx);
      return out_state_all[idx*128 +: 128];
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Present a word and hold it for exactly the accepting edge; returns at the following negedge.
   task automatic send(input int idx, input vec_t v, input string tag);
      @(negedge clk);
      in_state      = v.st;
      in_final      = v.fin;
      in_valid[idx] = 1'b1;
      check($sformatf("%s in_ready", tag), 128'(in_ready[idx]), 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid[idx] = 1'b0;
   endtask

   // Called at the negedge just after the accepting edge; counts edges until out_valid.
   task automatic wait_out(input int idx, input int lat_exp, input logic [127:0] exp, input string tag);
      int lat = 0;
      while (!out_valid[idx] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s latency", tag), 128'(lat), 128'(lat_exp));
      check($sformatf("%s out_state", tag), out_st(idx), exp);
   endtask

   task automatic drain(input int idx, input string tag);
      out_ready[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[idx] = 1'b0;
      check($sformatf("%s out_valid after drain", tag), 128'(out_valid[idx]), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
                  128'h046681e5_e0cb199a_48f8d37a_2806264c};
      vecs[1] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                  128'h00112233_44556677_8899aabb_ccddeeff};
      vecs[2] = '{128'h80808080_01010101_c6c6c6c6_f20a225c, 1'b0,
                  128'h80808080_01010101_c6c6c6c6_9fdc589d};
      vecs[3] = '{128'hdb135345_2d26314c_d4d4d4d5_f20a225c, 1'b0,
                  128'h8e4da1bc_4d7ebdf8_d5d5d7d6_9fdc589d};

      in_valid  = '0;
      out_ready = '0;
      in_state  = '0;
      in_final  = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset dut%0d out_valid", i), 128'(out_valid[i]), 128'd0);
         check($sformatf("reset dut%0d out_state", i), out_st(i), 128'd0);
         check($sformatf("reset dut%0d in_ready", i), 128'(in_ready[i]), 128'd1);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Table: every vector through every column width, latency 4/COLS_PER_CYCLE.
      for (int i = 0; i < 3; i++) begin
         for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("cpc%0d vec%0d", 1 << i, v);
            send(i, vecs[v], tag);
            wait_out(i, 4 >> i, vecs[v].exp, tag);
            drain(i, tag);
         end
      end

      // Downstream stall for 10 cycles, then simultaneous output and input handshakes.
      send(0, vecs[0], "stall");
      wait_out(0, 4, vecs[0].exp, "stall");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d out_valid", k), 128'(out_valid[0]), 128'd1);
         check($sformatf("stall%0d out_state", k), out_st(0), vecs[0].exp);
         check($sformatf("stall%0d in_ready", k), 128'(in_ready[0]), 128'd0);
      end
      in_state     = vecs[2].st;
      in_final     = vecs[2].fin;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      #1;
      check("b2b in_ready follows out_ready", 128'(in_ready[0]), 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      check("b2b out_valid dropped", 128'(out_valid[0]), 128'd0);
      wait_out(0, 4, vecs[2].exp, "b2b");
      drain(0, "b2b");

      // Asynchronous reset in the second BUSY cycle discards the word.
      send(0, vecs[3], "rst");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 128'(out_valid[0]), 128'd0);
      check("rst out_state", out_st(0), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst in_ready after release", 128'(in_ready[0]), 128'd1);
      check("rst out_valid after release", 128'(out_valid[0]), 128'd0);
      send(0, vecs[0], "post-rst");
      wait_out(0, 4, vecs[0].exp, "post-rst");
      drain(0, "post-rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
